// File: rtl/cdc_sched_pkg.sv
// cdc_sched_pkg: shared state encoding and width helper for the CDC event scheduler
package cdc_sched_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, GAP} sched_state_e;
  function automatic int width_for(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/round_robin_arbiter.sv
// round_robin_arbiter: combinational winner search starting just after the last grant
module round_robin_arbiter
  import cdc_sched_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = width_for(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);
  // walk offsets from farthest to nearest so the nearest requester wins
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = N; i >= 1; i--) begin
      if (req_i[IW'((int'(last_i) + i) % N)]) begin
        idx_o   = IW'((int'(last_i) + i) % N);
        valid_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/cdc_event_scheduler.sv
// cdc_event_scheduler: shares one pulse synchronizer among several requesters,
// round-robin, with ack/timeout handshake and an enforced idle gap between pulses
module cdc_event_scheduler
  import cdc_sched_pkg::*;
#(
  parameter  int REQUESTERS     = 4,
  parameter  int GAP_CYCLES     = 8,
  parameter  int TIMEOUT_CYCLES = 255,
  localparam int ID_W           = width_for(REQUESTERS)
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [REQUESTERS-1:0] event_i,
  input  logic                  ack_i,
  output logic                  pulse_o,
  output logic [ID_W-1:0]       event_id_o,
  output logic [REQUESTERS-1:0] pending_o,
  output logic                  busy_o,
  output logic                  timeout_o,
  output logic                  overrun_o
);
  localparam int CNT_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = width_for(CNT_MAX + 1);
  sched_state_e          state_q, state_d;
  logic [REQUESTERS-1:0] pending_q, pending_d, grant_mask;
  logic [ID_W-1:0]       last_grant_q, last_grant_d, event_id_q, event_id_d, win_idx;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
  logic                  pulse_q, pulse_d, busy_q, busy_d, timeout_q, timeout_d;
  logic                  overrun_q, overrun_d, win_valid;
  round_robin_arbiter #(.N(REQUESTERS), .IW(ID_W)) u_arb (
    .req_i   (pending_q),
    .last_i  (last_grant_q),
    .idx_o   (win_idx),
    .valid_o (win_valid)
  );
  // an event landing on the bit being granted survives the clear
  always_comb begin
    grant_mask   = (state_q == IDLE && win_valid) ? REQUESTERS'(1) << win_idx : '0;
    pending_d    = (pending_q & ~grant_mask) | event_i;
    overrun_d    = |(event_i & pending_q & ~grant_mask);
    cnt_inc      = (cnt_q == CNT_W'(CNT_MAX)) ? cnt_q : cnt_q + 1'b1;
    state_d      = state_q;
    last_grant_d = last_grant_q;
    event_id_d   = event_id_q;
    cnt_d        = '0;
    timeout_d    = 1'b0;
    case (state_q)
      IDLE: if (win_valid) begin
        state_d      = ISSUE;
        event_id_d   = win_idx;
        last_grant_d = win_idx;
      end
      ISSUE: state_d = WAIT_ACK;
      WAIT_ACK: begin
        state_d   = (ack_i || cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) ? GAP : WAIT_ACK;
        timeout_d = !ack_i && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);
        cnt_d     = (state_d == GAP) ? '0 : cnt_inc;
      end
      GAP: begin
        state_d = (cnt_q == CNT_W'(GAP_CYCLES - 1)) ? IDLE : GAP;
        cnt_d   = (state_d == IDLE) ? '0 : cnt_inc;
      end
      default: state_d = IDLE;
    endcase
    pulse_d = state_d == ISSUE;
    busy_d  = state_d != IDLE;
  end
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      last_grant_q <= ID_W'(REQUESTERS - 1);
      event_id_q   <= '0;
      cnt_q        <= '0;
      pulse_q      <= 1'b0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      last_grant_q <= last_grant_d;
      event_id_q   <= event_id_d;
      cnt_q        <= cnt_d;
      pulse_q      <= pulse_d;
      busy_q       <= busy_d;
      timeout_q    <= timeout_d;
      overrun_q    <= overrun_d;
    end
  end
  assign pulse_o    = pulse_q;
  assign event_id_o = event_id_q;
  assign pending_o  = pending_q;
  assign busy_o     = busy_q;
  assign timeout_o  = timeout_q;
  assign overrun_o  = overrun_q;
endmodule

// File: tb/tb_cdc_event_scheduler.sv
// tb_cdc_event_scheduler: directed scenarios with a grant-ID scoreboard and timing checks
module tb_cdc_event_scheduler;
  logic       clk_i = 1'b0;
  logic       rstn_i = 1'b0;
  logic [3:0] event_i = '0;
  logic       ack_i = 1'b0;
  logic       pulse_o, busy_o, timeout_o, overrun_o;
  logic [1:0] event_id_o;
  logic [3:0] pending_o;
  int vectors = 0, miscompares = 0, cyc = 0, tmo_n = 0;
  int sb[$];
  int t0, p, p2, c;
  int pc[4];
  cdc_event_scheduler dut (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .event_i    (event_i),
    .ack_i      (ack_i),
    .pulse_o    (pulse_o),
    .event_id_o (event_id_o),
    .pending_o  (pending_o),
    .busy_o     (busy_o),
    .timeout_o  (timeout_o),
    .overrun_o  (overrun_o)
  );
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk_i) begin
    if (timeout_o === 1'b1) tmo_n++;
    if (rstn_i && pulse_o === 1'b1) begin
      if (sb.size() == 0) chk("sb_nonempty_at_pulse", sb.size(), 1);
      else chk("grant_id", {30'b0, event_id_o}, sb.pop_front());
    end
  end
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic wait_pulse(input string tag, output int t);
    t = -1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk_i);
      if (pulse_o === 1'b1) begin
        t = cyc;
        break;
      end
    end
    chk(tag, {31'b0, pulse_o}, 1);
  endtask
  task automatic wait_idle(input string tag, output int t);
    t = -1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk_i);
      if (busy_o === 1'b0) begin
        t = cyc;
        break;
      end
    end
    chk(tag, {31'b0, busy_o}, 0);
  endtask
  task automatic ack_next();
    tick();
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
  endtask
  task automatic chk_quiet(input string tag);
    chk({tag, "_pulse"}, {31'b0, pulse_o}, 0);
    chk({tag, "_busy"}, {31'b0, busy_o}, 0);
    chk({tag, "_timeout"}, {31'b0, timeout_o}, 0);
    chk({tag, "_overrun"}, {31'b0, overrun_o}, 0);
    chk({tag, "_id"}, {30'b0, event_id_o}, 0);
    chk({tag, "_pending"}, {28'b0, pending_o}, 0);
  endtask
  initial begin
    repeat (3) tick();
    @(negedge clk_i);
    chk_quiet("reset");
    tick();
    rstn_i = 1'b1;
    tick();
    // round-robin from reset: 0,1,2,3 spaced by 3+GAP_CYCLES
    event_i = 4'b1111;
    t0 = cyc;
    sb.push_back(0); sb.push_back(1); sb.push_back(2); sb.push_back(3);
    tick();
    event_i = '0;
    for (int k = 0; k < 4; k++) begin
      wait_pulse("rr_pulse", pc[k]);
      ack_next();
    end
    chk("rr_latency", pc[0] - t0, 2);
    for (int k = 1; k < 4; k++) chk("rr_spacing", pc[k] - pc[k-1], 11);
    wait_idle("rr_idle", c);
    // single event with late ack
    tick();
    event_i = 4'b0100;
    t0 = cyc;
    sb.push_back(2);
    tick();
    event_i = '0;
    @(negedge clk_i);
    chk("single_pending", {28'b0, pending_o}, 4'b0100);
    wait_pulse("single_pulse", p);
    chk("single_latency", p - t0, 2);
    chk("single_busy", {31'b0, busy_o}, 1);
    repeat (5) tick();
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
    wait_idle("single_idle", c);
    chk("single_busy_span", c - p, 14);
    chk("single_no_timeout", tmo_n, 0);
    // timeout, then the queued request is served
    tick();
    event_i = 4'b0001;
    sb.push_back(0);
    tick();
    event_i = '0;
    wait_pulse("tmo_pulse", p);
    tick();
    event_i = 4'b1000;
    sb.push_back(3);
    tick();
    event_i = '0;
    c = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_i);
      if (timeout_o === 1'b1) begin
        c = cyc;
        break;
      end
    end
    chk("tmo_seen", {31'b0, timeout_o}, 1);
    chk("tmo_delay", c - p, 256);
    @(negedge clk_i);
    chk("tmo_one_cycle", {31'b0, timeout_o}, 0);
    wait_pulse("tmo_next_pulse", p2);
    chk("tmo_next_spacing", p2 - p, 265);
    ack_next();
    wait_idle("tmo_idle", c);
    chk("tmo_count", tmo_n, 1);
    // overrun once on double event; event in own grant cycle is kept
    tick();
    event_i = 4'b0001;
    sb.push_back(0);
    tick();
    event_i = '0;
    wait_pulse("ovr_pulse", p);
    tick();
    ack_i = 1'b1;
    event_i = 4'b0010;
    sb.push_back(1);
    tick();
    ack_i = 1'b0;
    event_i = '0;
    @(negedge clk_i);
    chk("ovr_first_none", {31'b0, overrun_o}, 0);
    chk("ovr_pending", {28'b0, pending_o}, 4'b0010);
    tick();
    event_i = 4'b0010;
    tick();
    event_i = '0;
    @(negedge clk_i);
    chk("ovr_strobe", {31'b0, overrun_o}, 1);
    tick();
    @(negedge clk_i);
    chk("ovr_one_cycle", {31'b0, overrun_o}, 0);
    repeat (5) tick();
    event_i = 4'b0010;
    sb.push_back(1);
    tick();
    event_i = '0;
    @(negedge clk_i);
    chk("same_grant_pulse", {31'b0, pulse_o}, 1);
    chk("same_grant_kept", {28'b0, pending_o}, 4'b0010);
    chk("same_grant_no_ovr", {31'b0, overrun_o}, 0);
    p2 = cyc;
    ack_next();
    wait_pulse("same_grant_again", c);
    chk("same_grant_spacing", c - p2, 11);
    ack_next();
    wait_idle("ovr_idle", c);
    // spurious ack in IDLE and in GAP
    tick();
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
    @(negedge clk_i);
    chk("spur_idle_busy", {31'b0, busy_o}, 0);
    chk("spur_idle_pulse", {31'b0, pulse_o}, 0);
    tick();
    event_i = 4'b1000;
    sb.push_back(3);
    tick();
    event_i = '0;
    wait_pulse("spur_pulse", p);
    ack_next();
    tick();
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
    wait_idle("spur_gap_idle", c);
    chk("spur_gap_span", c - p, 10);
    chk("spur_no_timeout", tmo_n, 1);
    // reset during WAIT_ACK drops everything; requester 0 wins afterwards
    tick();
    event_i = 4'b0010;
    sb.push_back(1);
    tick();
    event_i = '0;
    wait_pulse("rst_pulse", p);
    tick();
    event_i = 4'b1000;
    tick();
    event_i = '0;
    @(negedge clk_i);
    chk("rst_pre_pending", {28'b0, pending_o}, 4'b1000);
    tick();
    rstn_i = 1'b0;
    #1;
    chk_quiet("rst_mid");
    tick();
    tick();
    rstn_i = 1'b1;
    event_i = 4'b1001;
    sb.push_back(0);
    sb.push_back(3);
    tick();
    event_i = '0;
    wait_pulse("rst_first", p);
    ack_next();
    wait_pulse("rst_second", p2);
    ack_next();
    wait_idle("rst_idle", c);
    chk("sb_drained", sb.size(), 0);
    chk("final_timeouts", tmo_n, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cdc_event_scheduler.md
# cdc_event_scheduler

Source-domain scheduler that shares one pulse synchronizer channel (and its return acknowledge channel) between several event requesters. Captures single-cycle events into per-requester pending bits, grants them round-robin, and issues one pulse per grant with a quasi-static event ID that the destination samples on the synchronized pulse. It then waits for the returned acknowledge, or a timeout, and enforces a minimum gap before the next pulse. This keeps pulse spacing and data stability legal for the synchronizer.

## Interface
- REQUESTERS, 4: number of event sources, at least 2.
- GAP_CYCLES, 8: minimum idle cycles after each transfer completes, at least 1.
- TIMEOUT_CYCLES, 255: maximum cycles spent in WAIT_ACK, at least 1.
- ID_W, $clog2(REQUESTERS): event ID width (derived, not overridable).

- clk_i  in  1  single clock; every flop uses the rising edge.
- rstn_i  in  1  reset, asynchronous, active-low.
- event_i  in  REQUESTERS  single-cycle event strobes, one per requester.
- ack_i  in  1  single-cycle acknowledge from the return synchronizer.
- pulse_o  out  1  single-cycle pulse to the synchronizer source input.
- event_id_o  out  ID_W  ID of the granted requester; held stable from pulse_o until the next grant.
- pending_o  out  REQUESTERS  pending bits.
- busy_o  out  1  high in any state other than IDLE.
- timeout_o  out  1  one-cycle strobe when WAIT_ACK expires without ack_i.
- overrun_o  out  1  one-cycle strobe when an event hits an already-pending bit.

## Operation
- Pending capture:
  - event_i[k] sets pending[k].
  - A grant clears pending[k] at the edge entering ISSUE.
  - If event_i[k] arrives in the same cycle as the grant of k, pending[k] stays set and the new event is kept.
  - If event_i[k] arrives while pending[k] is set and k is not being granted, the events coalesce and overrun_o pulses.
- Arbitration:
  - Round-robin. Search starts at last_grant+1 and wraps modulo REQUESTERS.
  - last_grant resets to REQUESTERS-1, so requester 0 has top priority after reset.
- FSM states:
  - IDLE: if any pending bit is set, latch the winner into event_id_o, update last_grant, go to ISSUE.
  - ISSUE: pulse_o=1 for exactly 1 cycle, then go to WAIT_ACK and clear the timeout counter.
  - WAIT_ACK:
    - ack_i goes to GAP.
    - If the counter reaches TIMEOUT_CYCLES-1 without ack_i, pulse timeout_o and go to GAP.
    - ack_i in the expiry cycle wins: it goes to GAP with no timeout_o.
  - GAP: count GAP_CYCLES cycles, then go to IDLE.
- ack_i outside WAIT_ACK is ignored, with no side effects.
- Counters are sized for max(GAP_CYCLES, TIMEOUT_CYCLES). They saturate and never wrap.
- Reset values:
  - State IDLE; pending all 0.
  - pulse_o, busy_o, timeout_o, overrun_o = 0; event_id_o = 0.
  - Counters = 0; last_grant = REQUESTERS-1.
- Reset asserted mid-transfer aborts immediately with no pulse or strobe; pending events are lost.

## Timing
- Event-to-pulse latency, scheduler idle: event_i at cycle t → pending at t+1 → pulse_o at t+2.
- event_id_o changes only on the IDLE→ISSUE edge, and so is valid in the same cycle as pulse_o.
- Minimum pulse-to-pulse spacing is 3+GAP_CYCLES cycles: ISSUE, at least one WAIT_ACK cycle, GAP_CYCLES, and IDLE.
- timeout_o fires TIMEOUT_CYCLES cycles after the first WAIT_ACK cycle.
- overrun_o is registered and appears 1 cycle after the offending event_i.

## Structure
- Package cdc_sched_pkg holds the state enum (IDLE, ISSUE, WAIT_ACK, GAP) and a clog2-based width helper.
- Sub-module round_robin_arbiter: combinational winner search over pending and last_grant, producing an index and a valid flag. Reusable elsewhere.
- The top level holds the FSM, pending register, counters and output registers.

## Test plan
- Single event: event_i=4'b0100 at t0 → pulse_o at t0+2 with event_id_o=2; ack_i 5 cycles later → IDLE after 8 GAP cycles; busy_o high throughout.
- Round-robin: all four events at once, ack 1 cycle after each pulse → grants 0,1,2,3, each pulse spaced exactly 11 cycles apart.
- Timeout: no ack_i → timeout_o pulses exactly 255 cycles after entering WAIT_ACK, then GAP, and the next pending request is served.
- Overrun and simultaneity:
  - event_i[1] twice while pending → overrun_o once.
  - event_i[1] in its own grant cycle → pending[1] remains 1 and is served again later.
- Spurious ack and reset: ack_i in IDLE or GAP → no state change. rstn_i low during WAIT_ACK → all outputs 0, pending cleared, and the first grant after reset goes to requester 0.
